// File: rtl/roulette_spin_animator.sv
// Roulette wheel spin sequencer: steps the lit pocket around the wheel at constant
// speed, decelerates linearly over the final steps and lands exactly on the target.
module roulette_spin_animator #(
  parameter int POCKETS     = 38,
  parameter int PW          = 6,
  parameter int BANKS       = 5,
  parameter int LAPS_MIN    = 3,
  parameter int START_DIV   = 2000000,
  parameter int STEP_INC    = 250000,
  parameter int DECEL_STEPS = 16,
  parameter int DIV_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PW-1:0]    target,
  output logic [PW-1:0]    led_number,
  output logic [BANKS-1:0] led_bank,
  output logic [2:0]       led_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_dbg
);

  localparam int SL_W = $clog2(LAPS_MIN * POCKETS + POCKETS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPIN  = 2'd1,
    DECEL = 2'd2,
    LAND  = 2'd3
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  period;
  logic [SL_W-1:0]   steps_left;

  logic              target_ok;
  logic [SL_W-1:0]   offset;
  logic [SL_W-1:0]   spin_steps;
  logic              step_hit;
  logic [PW-1:0]     next_number;

  // start is a one-cycle request: it is honoured only in IDLE (busy low); while
  // busy it is dropped and target is not resampled.
  function automatic logic [BANKS-1:0] bank_of(input logic [PW-1:0] n);
    bank_of = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank_of[b] = ((32'(n) >> 3) == 32'(b));
    end
  endfunction

  always_comb begin
    target_ok = 1'b0;
    offset    = '0;
    if (32'(target) < 32'(POCKETS)) begin
      target_ok = 1'b1;
    end
    if (target >= led_number) begin
      offset = SL_W'(target) - SL_W'(led_number);
    end else begin
      offset = SL_W'(target) + SL_W'(POCKETS) - SL_W'(led_number);
    end
    spin_steps = SL_W'(LAPS_MIN * POCKETS) + offset;
  end

  always_comb begin
    step_hit = 1'b0;
    if ((state == SPIN) || (state == DECEL)) begin
      step_hit = (cnt == period - DIV_W'(1));
    end
    if (led_number == PW'(POCKETS - 1)) begin
      next_number = '0;
    end else begin
      next_number = led_number + PW'(1);
    end
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      led_number <= '0;
      led_bank   <= BANKS'(1);
      led_sel    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
      period     <= '0;
      steps_left <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (target_ok) begin
              steps_left <= spin_steps;
              cnt        <= '0;
              busy       <= 1'b1;
              // A spin no longer than the deceleration tail starts decelerating at once.
              if (spin_steps <= SL_W'(DECEL_STEPS)) begin
                state  <= DECEL;
                period <= DIV_W'(START_DIV + STEP_INC);
              end else begin
                state  <= SPIN;
                period <= DIV_W'(START_DIV);
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        SPIN, DECEL: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (step_hit) begin
            cnt        <= '0;
            steps_left <= steps_left - SL_W'(1);
            led_number <= next_number;
            led_bank   <= bank_of(next_number);
            led_sel    <= next_number[2:0];
            if (steps_left == SL_W'(1)) begin
              state <= LAND;
            end else if ((state == SPIN) && (steps_left == SL_W'(DECEL_STEPS + 1))) begin
              state  <= DECEL;
              period <= DIV_W'(START_DIV + STEP_INC);
            end else if (state == DECEL) begin
              period <= period + DIV_W'(STEP_INC);
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        LAND: begin
          // First LAND cycle raises done; the second releases busy.
          if (!done) begin
            done <= 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roulette_spin_animator.sv
// Bench for roulette_spin_animator: a small 8-pocket wheel and a 38-pocket wheel with
// short dividers, checked cycle by cycle against a step-time reference model.
module tb_roulette_spin_animator;

  localparam int A_N = 8,  A_PW = 4, A_BANKS = 1, A_LAPS = 1, A_SD = 4, A_INC = 2, A_D = 3;
  localparam int B_N = 38, B_PW = 6, B_BANKS = 5, B_LAPS = 3, B_SD = 3, B_INC = 2, B_D = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               start_a, abort_a, busy_a, done_a, err_a;
  logic [A_PW-1:0]    target_a, num_a;
  logic [A_BANKS-1:0] bank_a;
  logic [2:0]         sel_a;
  logic [1:0]         st_a;

  logic               start_b, abort_b, busy_b, done_b, err_b;
  logic [B_PW-1:0]    target_b, num_b;
  logic [B_BANKS-1:0] bank_b;
  logic [2:0]         sel_b;
  logic [1:0]         st_b;

  roulette_spin_animator #(
    .POCKETS(A_N), .PW(A_PW), .BANKS(A_BANKS), .LAPS_MIN(A_LAPS),
    .START_DIV(A_SD), .STEP_INC(A_INC), .DECEL_STEPS(A_D), .DIV_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .target(target_a),
    .led_number(num_a), .led_bank(bank_a), .led_sel(sel_a),
    .busy(busy_a), .done(done_a), .err(err_a), .state_dbg(st_a)
  );

  roulette_spin_animator #(
    .POCKETS(B_N), .PW(B_PW), .BANKS(B_BANKS), .LAPS_MIN(B_LAPS),
    .START_DIV(B_SD), .STEP_INC(B_INC), .DECEL_STEPS(B_D), .DIV_W(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .target(target_b),
    .led_number(num_b), .led_bank(bank_b), .led_sel(sel_b),
    .busy(busy_b), .done(done_b), .err(err_b), .state_dbg(st_b)
  );

  int total = 0;
  int bad   = 0;
  int pos_q[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] obs_num(input int w);
    return (w != 0) ? 32'(num_b) : 32'(num_a);
  endfunction
  function automatic logic [31:0] obs_bank(input int w);
    return (w != 0) ? 32'(bank_b) : 32'(bank_a);
  endfunction
  function automatic logic [31:0] obs_sel(input int w);
    return (w != 0) ? 32'(sel_b) : 32'(sel_a);
  endfunction
  function automatic logic [31:0] obs_busy(input int w);
    return (w != 0) ? 32'(busy_b) : 32'(busy_a);
  endfunction
  function automatic logic [31:0] obs_done(input int w);
    return (w != 0) ? 32'(done_b) : 32'(done_a);
  endfunction
  function automatic logic [31:0] obs_err(input int w);
    return (w != 0) ? 32'(err_b) : 32'(err_a);
  endfunction

  // driver
  task automatic set_in(input int w, input logic s, input logic a, input int tgt);
    if (w != 0) begin
      start_b = s; abort_b = a; target_b = B_PW'(tgt);
    end else begin
      start_a = s; abort_a = a; target_a = A_PW'(tgt);
    end
  endtask

  task automatic check_pos(input int w, input int pos);
    check("led_number", obs_num(w), 32'(pos));
    check("led_bank", obs_bank(w), 32'(1 << (pos / 8)));
    check("led_sel", obs_sel(w), 32'(pos % 8));
  endtask

  // One spin: the model lists every step time, then the wheel is watched each cycle.
  // abort_cyc/mid_cyc/stop_cyc are cycle numbers after the accepting edge (0 = unused).
  task automatic spin(input int w, input int tgt, input int abort_cyc, input int mid_cyc,
                      input int stop_cyc);
    int n_p, laps, sd, inc, d, p0, s, t, tl, end_cyc, n, pos;
    int times[$];
    logic act;
    n_p  = (w != 0) ? B_N : A_N;
    laps = (w != 0) ? B_LAPS : A_LAPS;
    sd   = (w != 0) ? B_SD : A_SD;
    inc  = (w != 0) ? B_INC : A_INC;
    d    = (w != 0) ? B_D : A_D;
    p0   = pos_q[w];
    s    = laps * n_p + (((tgt - p0) % n_p) + n_p) % n_p;
    t    = 0;
    for (int i = 1; i <= s; i++) begin
      t += (i > s - d) ? sd + (i - (s - d)) * inc : sd;
      times.push_back(t);
    end
    tl = t;
    end_cyc = (stop_cyc != 0) ? stop_cyc : ((abort_cyc != 0) ? abort_cyc + 8 : tl + 2);

    // abort alongside start in IDLE must be ignored
    set_in(w, 1'b1, 1'($urandom_range(0, 1)), tgt);
    tick();
    set_in(w, 1'b0, 1'b0, tgt);
    check("accept_busy", obs_busy(w), 32'd1);
    check("accept_num", obs_num(w), 32'(p0));

    for (int cyc = 1; cyc <= end_cyc; cyc++) begin
      if (cyc == mid_cyc) set_in(w, 1'b1, 1'b0, (tgt + 1) % n_p);
      if (cyc == abort_cyc) set_in(w, 1'b0, 1'b1, tgt);
      tick();
      set_in(w, 1'b0, 1'b0, tgt);
      n = 0;
      foreach (times[i]) begin
        if (times[i] <= cyc && (abort_cyc == 0 || times[i] < abort_cyc)) n++;
      end
      pos = (p0 + n) % n_p;
      act = (abort_cyc != 0) ? (cyc < abort_cyc) : (cyc <= tl + 1);
      check_pos(w, pos);
      check("busy", obs_busy(w), 32'(act));
      check("done", obs_done(w), 32'(abort_cyc == 0 && cyc == tl + 1));
      pos_q[w] = pos;
    end
  endtask

  task automatic reject(input int w, input int tgt);
    int p0;
    p0 = pos_q[w];
    set_in(w, 1'b1, 1'b0, tgt);
    tick();
    set_in(w, 1'b0, 1'b0, 0);
    check("err_pulse", obs_err(w), 32'd1);
    check("err_busy", obs_busy(w), 32'd0);
    check_pos(w, p0);
    tick();
    check("err_clear", obs_err(w), 32'd0);
    check("err_busy2", obs_busy(w), 32'd0);
    check_pos(w, p0);
  endtask

  initial begin
    int tgt;
    rst_n = 1'b0;
    set_in(0, 1'b0, 1'b0, 0);
    set_in(1, 1'b0, 1'b0, 0);
    pos_q[0] = 0;
    pos_q[1] = 0;
    #12;
    for (int w = 0; w < 2; w++) begin
      check_pos(w, 0);
      check("rst_busy", obs_busy(w), 32'd0);
      check("rst_done", obs_done(w), 32'd0);
      check("rst_err", obs_err(w), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    spin(0, 5, 0, 0, 0);      // 13 steps, last at 64, done at 65
    spin(0, 5, 0, 0, 0);      // same pocket: one full lap
    reject(0, 9);
    spin(0, 2, 16, 7, 0);     // abort on the 4th step edge, stray start at cycle 7

    // reset mid-deceleration: outputs must drop without a clock edge
    spin(0, 6, 0, 0, 47);
    #2;
    rst_n = 1'b0;
    #1;
    check_pos(0, 0);
    check("async_busy", obs_busy(0), 32'd0);
    check("async_done", obs_done(0), 32'd0);
    pos_q[0] = 0;
    pos_q[1] = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    spin(0, 3, 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      tgt = int'($urandom_range(0, 15));
      if (tgt >= A_N) reject(0, tgt);
      else spin(0, tgt, 0, int'($urandom_range(1, 20)), 0);
    end

    spin(1, 37, 0, 0, 0);     // lands in bank 4, select 5
    reject(1, int'($urandom_range(38, 63)));
    for (int r = 0; r < 3; r++) begin
      spin(1, int'($urandom_range(0, 37)), 0, int'($urandom_range(1, 100)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/roulette_spin_animator.md
# roulette_spin_animator

Parametrised wheel-spin sequencer that replaces the static pocket-number LED drive of the roulette board. The processor supplies a landing pocket and a start pulse. The block then steps the lit pocket around the wheel at constant speed for a fixed number of laps, decelerates linearly, and stops exactly on the target. It drives the pocket index plus decoded bank and select lines for the 8:1 LED multiplexers on the PMOD headers, and reports busy, done and error status back to the processor.

## Interface
- POCKETS, 38: number of wheel pockets; legal indices are 0..POCKETS-1.
- PW, 6: pocket index width; must satisfy 2^PW >= POCKETS.
- BANKS, 5: number of 8:1 LED mux banks; must equal ceil(POCKETS/8).
- LAPS_MIN, 3: full laps always taken before landing; must be >= 1.
- START_DIV, 2000000: clock cycles per step during constant-speed spin.
- STEP_INC, 250000: cycles added to the step period at each deceleration step.
- DECEL_STEPS, 16: number of final steps that decelerate; must be <= LAPS_MIN*POCKETS.
- DIV_W, 32: period counter width; START_DIV + DECEL_STEPS*STEP_INC must fit in DIV_W bits.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- start  in  1  single-cycle request to begin a spin.
- abort  in  1  cancels a spin in progress.
- target  in  PW  landing pocket; sampled on the cycle start is accepted.
- led_number  out  PW  currently lit pocket.
- led_bank  out  BANKS  one-hot bank enable; bit led_number>>3 is set.
- led_sel  out  3  mux select, equal to led_number[2:0].
- busy  out  1  high while a spin is in progress.
- done  out  1  one-cycle pulse when the wheel lands on the target.
- err  out  1  one-cycle pulse when start is rejected because target >= POCKETS.

## Operation
- States are IDLE, SPIN, DECEL and LAND.
  - Reset forces IDLE, led_number=0, led_bank=1, led_sel=0, busy=0, done=0, err=0, and clears all counters.
- **IDLE, start=1, target < POCKETS:** accept the spin.
  - Latch steps_left = LAPS_MIN*POCKETS + ((target - led_number) mod POCKETS).
  - Clear the period counter and go to SPIN.
- **IDLE, start=1, target >= POCKETS:** pulse err next cycle and stay in IDLE. led_number does not change.
- **IDLE, abort=1:** ignored. If start and abort are both high in IDLE, start wins.
- **Stepping:** the period counter counts 1..P. On the cycle it reaches P:
  - led_number advances by one, wrapping from POCKETS-1 to 0;
  - steps_left decrements;
  - the counter reloads to 1.
- **Step period P:**
  - SPIN: P = START_DIV.
  - DECEL, k-th decel step (k = 1..DECEL_STEPS): P = START_DIV + k*STEP_INC.
- **SPIN -> DECEL:** on the step where steps_left becomes DECEL_STEPS.
- **DECEL -> LAND:** on the step where steps_left becomes 0. At that point led_number == target.
- **LAND:** done=1 for exactly one cycle, then IDLE. led_number holds its value until the next spin.
- **target == led_number at accept:** exactly LAPS_MIN full laps, landing back on the same pocket.
- **start while busy:** ignored; target is not resampled.
- **abort in SPIN or DECEL:** go to IDLE on the next edge with busy=0 and no done pulse. led_number freezes at its current value. If abort coincides with a step edge, abort wins and the step is not taken.
- **reset low mid-spin:** outputs return to reset values immediately, without waiting for a clock edge.
- **Output encoding:** led_bank and led_sel are registered alongside led_number, so all three always change on the same edge.

## Timing
- busy rises on the edge after start is sampled and stays high through LAND. It falls the cycle after the done pulse.
- The first step occurs START_DIV cycles after the accepting edge.
- Let S = steps_left at accept. The last step occurs S*START_DIV + STEP_INC*DECEL_STEPS*(DECEL_STEPS+1)/2 cycles after the accepting edge.
- done is high in the cycle after the last step.
- err is high in the cycle after the rejected start.
- A new start is accepted on the first cycle busy is low.

## Test plan
Scenarios 1-5 use POCKETS=8, BANKS=1, LAPS_MIN=1, START_DIV=4, STEP_INC=2, DECEL_STEPS=3.
1. From reset (led_number=0), start with target=5 -> S=13; the last step lands at 5 after 13*4 + 2*6 = 64 cycles; done pulses at cycle 65; busy low at cycle 66.
2. With led_number=5, start with target=5 -> S=8; led_number shows 6,7,0,...,5 in order; the last three step gaps are 6, 8 and 10 cycles.
3. Start with target=9 -> err pulses one cycle; busy stays 0; led_number stays unchanged.
4. Assert abort on the same cycle as the 4th step edge -> led_number holds at its 3rd-step value; busy drops next cycle; done never pulses. A second start pulse raised mid-spin is ignored.
5. Drive reset low mid-DECEL -> led_number=0, led_bank=1, busy=0 asynchronously. After release, start with target=3 lands correctly on 3.
6. Default parameters, target=37 -> lands at 37 with led_bank=5'b10000 and led_sel=3'b101. Check bank and select decode at every step.
